dpram_param: RTL and testbench
==============================

// Module: dpram_param
// PURPOSE
//  Parametrised successor of the 8-bit dual-port RAM: one write port, one read port, single clock.
//  Adds byte-enabled writes, 1- or 2-cycle read latency with data_valid, and a defined read/write collision mode.
//  Adds a post-reset zero-fill sequence with a ready flag and a saturating collision counter.
//  Drop-in storage for testbench DUT slots and datapath buffers; drivers use the same master/slave/monitor signal set.
// PARAMETERS
//  DATA_WIDTH    32  word width in bits; multiple of 8, range 8..128
//  ADDR_WIDTH    8   address width; DEPTH = 2**ADDR_WIDTH words
//  READ_LATENCY  1   cycles from sampled read_enable to data_valid; legal values 1 or 2
//  RW_MODE       0   same-address collision policy: 0 READ_FIRST (old data), 1 WRITE_FIRST (new data)
//  CNT_WIDTH     16  width of collision_count
// PORTS
//  clock          in   1             rising-edge clock
//  reset          in   1             asynchronous, active-high reset
//  write_enable   in   1             write request, sampled at posedge
//  write_address  in   ADDR_WIDTH    write word address
//  data_in        in   DATA_WIDTH    write data
//  byte_enable    in   DATA_WIDTH/8  per-byte write mask; bit i gates data_in[8i+7:8i]
//  read_enable    in   1             read request, sampled at posedge
//  read_address   in   ADDR_WIDTH    read word address
//  data_out       out  DATA_WIDTH    read data; valid only while data_valid=1
//  data_valid     out  1             data_out qualifier, one pulse per accepted read
//  ready          out  1             1 = zero-fill done, requests accepted
//  collision      out  1             registered 1-cycle pulse: an accepted read and write hit the same address
//  collision_count out CNT_WIDTH     saturating count of collisions since reset
// BEHAVIOUR
//  Reset (async assert; synchronous-release use): data_out=0, data_valid=0, ready=0, collision=0, collision_count=0.
//   Reset also sets FSM=INIT, fill_ptr=0, and clears the read pipeline. Memory contents are not reset directly.
//  FSM INIT: each cycle writes 0 to mem[fill_ptr], then fill_ptr++. On fill_ptr==DEPTH-1 the next state is RUN.
//   ready=1 from the DEPTH-th rising edge after reset deasserts (e.g. edge 256 for ADDR_WIDTH=8).
//  FSM RUN: terminal state; only reset leaves it.
//  While ready=0, write_enable and read_enable are ignored: no memory change, no data_valid, no collision.
//  Write (RUN): for each i with byte_enable[i]=1, mem[write_address] byte i <= data_in byte i. Takes effect at the same edge.
//   byte_enable=0 gives no memory change; the request still counts as a write for collision detection.
//  Read (RUN): accepted at edge T.
//   READ_LATENCY=1: data_out/data_valid updated at T+1.
//   READ_LATENCY=2: extra output register; update at T+2.
//   Back-to-back reads every cycle are supported; data_valid stays high continuously.
//  data_valid=0 cycles: data_out holds its last value (not zeroed).
//  Collision: read and write accepted in the same cycle with read_address==write_address.
//   READ_FIRST returns the pre-write word.
//   WRITE_FIRST returns the merged word: new bytes where byte_enable=1, old bytes elsewhere.
//   collision pulses at T+1, independent of READ_LATENCY.
//   collision_count increments at T+1 and saturates at 2**CNT_WIDTH-1; it does not wrap.
//  Different addresses in the same cycle: independent, no interaction.
//  Address wrap: none; the full ADDR_WIDTH range is valid storage.
//  Reset mid-operation (during INIT or RUN): in-flight reads are discarded and data_valid drops asynchronously.
//   INIT restarts from address 0; pre-reset contents are overwritten by the fill.
//  Elaboration checks: $fatal if DATA_WIDTH%8!=0, or if READ_LATENCY is not 1 or 2.
// STRUCTURE
//  dpram_pkg:
//   typedef enum logic {READ_FIRST, WRITE_FIRST} rw_mode_e
//   typedef enum logic {INIT, RUN} dpram_state_e
//   localparam function bytes(w) = w/8
//  Sub-module dpram_storage:
//   plain DEPTH x DATA_WIDTH array with byte-masked write port and registered read port, RW_MODE-aware. No reset.
//  Top holds: INIT FSM, fill mux into the storage write port, latency-2 output stage, collision detect and counter.
// TESTING (DATA_WIDTH=32, ADDR_WIDTH=8, READ_LATENCY=1, READ_FIRST unless noted)
//  1 Reset release, 300 idle cycles -> ready rises exactly 256 edges after release; a read of 0x7F returns 0x00000000.
//  2 Write 0xDEADBEEF @0x10 with be=4'b1111, then be=4'b0101 data 0x11223344 -> read @0x10 returns 0xDE22BE44.
//  3 Same-cycle write 0xAAAAAAAA @0x20 (old 0x0) and read @0x20 -> READ_FIRST: data_out=0x0, collision=1, count=1.
//    Same stimulus with WRITE_FIRST -> data_out=0xAAAAAAAA.
//  4 READ_LATENCY=2, reads @0..7 on 8 consecutive cycles -> data_valid high 8 cycles starting 2 edges after first read.
//    Data is returned in address order.
//  5 CNT_WIDTH=4, 20 collisions -> collision_count stops at 15 and never wraps.
//  6 Assert reset mid-burst with 3 reads in flight -> data_valid=0 immediately, no late valids.
//    ready=0, then refill completes and old data reads back as 0.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared types and helpers for the parametrised dual-port RAM.
package dpram_pkg;
  typedef enum logic {READ_FIRST = 1'b0, WRITE_FIRST = 1'b1} rw_mode_e;
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} dpram_state_e;

  function automatic int bytes(input int w);
    return w / 8;
  endfunction
endpackage

// File: rtl/dpram_if.sv
// Request/response signal set of the RAM: master drives requests, slave is the RAM, monitor observes.
interface dpram_if
  import dpram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                            write_enable;
  logic [ADDR_WIDTH-1:0]           write_address;
  logic [DATA_WIDTH-1:0]           data_in;
  logic [bytes(DATA_WIDTH)-1:0]    byte_enable;
  logic                            read_enable;
  logic [ADDR_WIDTH-1:0]           read_address;
  logic [DATA_WIDTH-1:0]           data_out;
  logic                            data_valid;
  logic                            ready;
  logic                            collision;
  logic [CNT_WIDTH-1:0]            collision_count;

  modport master (
    output write_enable, write_address, data_in, byte_enable, read_enable, read_address,
    input  data_out, data_valid, ready, collision, collision_count
  );
  modport slave (
    input  write_enable, write_address, data_in, byte_enable, read_enable, read_address,
    output data_out, data_valid, ready, collision, collision_count
  );
  modport monitor (
    input write_enable, write_address, data_in, byte_enable, read_enable, read_address,
          data_out, data_valid, ready, collision, collision_count
  );
endinterface

// File: rtl/dpram_storage.sv
// DEPTH x DATA_WIDTH array: byte-masked write port, registered read port, collision policy in the read mux.
module dpram_storage
  import dpram_pkg::*;
#(
  parameter int       DATA_WIDTH = 32,
  parameter int       ADDR_WIDTH = 8,
  parameter rw_mode_e RW_MODE    = READ_FIRST
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [bytes(DATA_WIDTH)-1:0] wbe,
  input  logic                         re,
  input  logic [ADDR_WIDTH-1:0]        raddr,
  output logic [DATA_WIDTH-1:0]        rdata
);
  localparam int NB = bytes(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] merged;

  // Full-word write of the merged value keeps the array write port simple.
  always_comb begin
    merged = mem[waddr];
    for (int i = 0; i < NB; i++)
      if (wbe[i]) merged[8*i +: 8] = wdata[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= merged;
    if (re) rdata <= (RW_MODE == WRITE_FIRST && we && waddr == raddr) ? merged : mem[raddr];
  end
endmodule

// File: rtl/dpram_param.sv
// Dual-port RAM top: zero-fill FSM, request gating, read latency stage, collision pulse and counter.
module dpram_param
  import dpram_pkg::*;
#(
  parameter int       DATA_WIDTH   = 32,
  parameter int       ADDR_WIDTH   = 8,
  parameter int       READ_LATENCY = 1,
  parameter rw_mode_e RW_MODE      = READ_FIRST,
  parameter int       CNT_WIDTH    = 16
) (
  input  logic   clock,
  input  logic   reset,
  dpram_if.slave bus
);
  localparam int NB = bytes(DATA_WIDTH);

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 128) begin : g_bad_dw
    $fatal(1, "dpram_param: DATA_WIDTH must be a multiple of 8 in 8..128");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $fatal(1, "dpram_param: READ_LATENCY must be 1 or 2");
  end

  dpram_state_e          state;
  logic [ADDR_WIDTH-1:0] fill_ptr;
  logic                  run, wr_acc, rd_acc, hit;
  logic                  s_we;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic [DATA_WIDTH-1:0] s_data, rdata;
  logic [NB-1:0]         s_be;
  logic [READ_LATENCY:0] vld_pipe;
  logic                  coll_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  assign run    = (state == RUN);
  assign wr_acc = run & bus.write_enable;
  assign rd_acc = run & bus.read_enable;
  assign hit    = wr_acc & rd_acc & (bus.write_address == bus.read_address);

  // During INIT the fill owns the write port; no read can be accepted then.
  assign s_we   = ~run | wr_acc;
  assign s_addr = run ? bus.write_address : fill_ptr;
  assign s_data = run ? bus.data_in : '0;
  assign s_be   = run ? bus.byte_enable : '1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= INIT;
      fill_ptr <= '0;
    end else if (!run) begin
      fill_ptr <= fill_ptr + ADDR_WIDTH'(1);
      if (fill_ptr == '1) state <= RUN;
    end
  end

  dpram_storage #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .RW_MODE   (RW_MODE)
  ) u_storage (
    .clk  (clock),
    .we   (s_we),
    .waddr(s_addr),
    .wdata(s_data),
    .wbe  (s_be),
    .re   (rd_acc),
    .raddr(bus.read_address),
    .rdata(rdata)
  );

  assign vld_pipe[0] = rd_acc;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) vld_pipe[READ_LATENCY:1] <= '0;
    else       vld_pipe[READ_LATENCY:1] <= vld_pipe[READ_LATENCY-1:0];
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] dout_q;
    always_ff @(posedge clock or posedge reset) begin
      if (reset)            dout_q <= '0;
      else if (vld_pipe[1]) dout_q <= rdata;
    end
    assign bus.data_out = dout_q;
  end else begin : g_lat1
    // The storage read register has no reset; mask it until the first read after reset lands.
    logic held;
    always_ff @(posedge clock or posedge reset) begin
      if (reset)            held <= 1'b0;
      else if (vld_pipe[1]) held <= 1'b1;
    end
    assign bus.data_out = (held | vld_pipe[1]) ? rdata : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      coll_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      coll_q <= hit;
      if (hit && cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.data_valid      = vld_pipe[READ_LATENCY];
  assign bus.ready           = run;
  assign bus.collision       = coll_q;
  assign bus.collision_count = cnt_q;
endmodule

// File: tb/tb_dpram_param.sv
// Directed bench: four RAM configurations share one stimulus stream; expected values are hand-computed.
module tb_dpram_param;
  import dpram_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0, re = 1'b0;
  logic [7:0]  wa = '0, ra = '0;
  logic [31:0] din = '0;
  logic [3:0]  be = '0;

  int total = 0;
  int passed = 0;

  always #5 clock = ~clock;

  dpram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .CNT_WIDTH(16)) i0 ();
  dpram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .CNT_WIDTH(16)) i1 ();
  dpram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .CNT_WIDTH(16)) i2 ();
  dpram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .CNT_WIDTH(4))  i3 ();

  assign i0.write_enable = we;  assign i0.write_address = wa;  assign i0.data_in = din;
  assign i0.byte_enable  = be;  assign i0.read_enable   = re;  assign i0.read_address = ra;
  assign i1.write_enable = we;  assign i1.write_address = wa;  assign i1.data_in = din;
  assign i1.byte_enable  = be;  assign i1.read_enable   = re;  assign i1.read_address = ra;
  assign i2.write_enable = we;  assign i2.write_address = wa;  assign i2.data_in = din;
  assign i2.byte_enable  = be;  assign i2.read_enable   = re;  assign i2.read_address = ra;
  assign i3.write_enable = we;  assign i3.write_address = wa;  assign i3.data_in = din;
  assign i3.byte_enable  = be;  assign i3.read_enable   = re;  assign i3.read_address = ra;

  dpram_param #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(1), .RW_MODE(READ_FIRST), .CNT_WIDTH(16))
    d0 (.clock(clock), .reset(reset), .bus(i0));
  dpram_param #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(1), .RW_MODE(WRITE_FIRST), .CNT_WIDTH(16))
    d1 (.clock(clock), .reset(reset), .bus(i1));
  dpram_param #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(2), .RW_MODE(READ_FIRST), .CNT_WIDTH(16))
    d2 (.clock(clock), .reset(reset), .bus(i2));
  dpram_param #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(1), .RW_MODE(READ_FIRST), .CNT_WIDTH(4))
    d3 (.clock(clock), .reset(reset), .bus(i3));

  typedef struct {
    logic        we;
    logic [7:0]  wa;
    logic [31:0] din;
    logic [3:0]  be;
    logic        re;
    logic [7:0]  ra;
    logic        vld;
    logic [31:0] d_rf;
    logic [31:0] d_wf;
    logic        coll;
    logic [15:0] cnt;
  } vec_t;

  vec_t tv [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; wa = '0; ra = '0; din = '0; be = '0;
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  // Requests are driven throughout the fill; they must all be ignored.
  task automatic wait_ready(input string tag);
    int n0 = -1, n2 = -1, bad = 0;
    we = 1'b1; wa = 8'h7F; din = 32'hFFFF_FFFF; be = 4'hF; re = 1'b1; ra = 8'h7F;
    for (int n = 1; n <= 300 && n0 < 0; n++) begin
      step();
      if (i0.data_valid || i2.data_valid || i0.collision || i2.collision) bad++;
      if (i0.ready && n0 < 0) n0 = n;
      if (i2.ready && n2 < 0) n2 = n;
    end
    idle();
    chk({tag, " ready edge rl1"}, 64'(n0), 64'd256);
    chk({tag, " ready edge rl2"}, 64'(n2), 64'd256);
    chk({tag, " quiet during fill"}, 64'(bad), 64'd0);
  endtask

  initial begin
    tv[0]  = '{1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b0, 8'h00, 1'b0, 32'h0,        32'h0,        1'b0, 16'd0};
    tv[1]  = '{1'b1, 8'h10, 32'h11223344, 4'h5, 1'b0, 8'h00, 1'b0, 32'h0,        32'h0,        1'b0, 16'd0};
    tv[2]  = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h10, 1'b1, 32'hDE22BE44, 32'hDE22BE44, 1'b0, 16'd0};
    tv[3]  = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b0, 8'h00, 1'b0, 32'hDE22BE44, 32'hDE22BE44, 1'b0, 16'd0};
    tv[4]  = '{1'b1, 8'h20, 32'hAAAAAAAA, 4'hF, 1'b1, 8'h20, 1'b1, 32'h0,        32'hAAAAAAAA, 1'b1, 16'd1};
    tv[5]  = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b0, 8'h00, 1'b0, 32'h0,        32'hAAAAAAAA, 1'b0, 16'd1};
    tv[6]  = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h20, 1'b1, 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0, 16'd1};
    tv[7]  = '{1'b1, 8'h20, 32'h55555555, 4'h3, 1'b1, 8'h20, 1'b1, 32'hAAAAAAAA, 32'hAAAA5555, 1'b1, 16'd2};
    tv[8]  = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h20, 1'b1, 32'hAAAA5555, 32'hAAAA5555, 1'b0, 16'd2};
    tv[9]  = '{1'b1, 8'h30, 32'h12345678, 4'hF, 1'b1, 8'h10, 1'b1, 32'hDE22BE44, 32'hDE22BE44, 1'b0, 16'd2};
    tv[10] = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h30, 1'b1, 32'h12345678, 32'h12345678, 1'b0, 16'd2};
    tv[11] = '{1'b1, 8'h40, 32'hFFFFFFFF, 4'h0, 1'b1, 8'h40, 1'b1, 32'h0,        32'h0,        1'b1, 16'd3};
    tv[12] = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h40, 1'b1, 32'h0,        32'h0,        1'b0, 16'd3};
    tv[13] = '{1'b1, 8'hFF, 32'hCAFEF00D, 4'hF, 1'b1, 8'h00, 1'b1, 32'h0,        32'h0,        1'b0, 16'd3};
    tv[14] = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'hFF, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 16'd3};
    tv[15] = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h10, 1'b1, 32'hDE22BE44, 32'hDE22BE44, 1'b0, 16'd3};
    tv[16] = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h30, 1'b1, 32'h12345678, 32'h12345678, 1'b0, 16'd3};

    // Reset state
    #2;
    chk("rst data_out",  64'(i0.data_out), 64'd0);
    chk("rst valid",     64'(i0.data_valid), 64'd0);
    chk("rst ready",     64'(i0.ready), 64'd0);
    chk("rst collision", 64'(i0.collision), 64'd0);
    chk("rst count",     64'(i0.collision_count), 64'd0);
    chk("rst data_out rl2", 64'(i2.data_out), 64'd0);
    repeat (2) step();
    reset = 1'b0;
    wait_ready("init");

    re = 1'b1; ra = 8'h7F;
    step();
    idle();
    chk("fill read valid", 64'(i0.data_valid), 64'd1);
    chk("fill read data",  64'(i0.data_out), 64'd0);
    chk("fill read data wf", 64'(i1.data_out), 64'd0);
    step();

    // Byte enables, collisions, independence, hold behaviour
    for (int i = 0; i < 17; i++) begin
      we = tv[i].we; wa = tv[i].wa; din = tv[i].din; be = tv[i].be; re = tv[i].re; ra = tv[i].ra;
      step();
      chk($sformatf("v%0d valid", i),   64'(i0.data_valid), 64'(tv[i].vld));
      chk($sformatf("v%0d data rf", i), 64'(i0.data_out), 64'(tv[i].d_rf));
      chk($sformatf("v%0d data wf", i), 64'(i1.data_out), 64'(tv[i].d_wf));
      chk($sformatf("v%0d coll rf", i), 64'(i0.collision), 64'(tv[i].coll));
      chk($sformatf("v%0d coll wf", i), 64'(i1.collision), 64'(tv[i].coll));
      chk($sformatf("v%0d count", i),   64'(i0.collision_count), 64'(tv[i].cnt));
    end
    idle();
    step();

    // Latency 1 vs 2 burst
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; wa = 8'(i); din = 32'hA0 + 32'(i); be = 4'hF;
      step();
    end
    idle();
    for (int j = 0; j < 11; j++) begin
      re = (j < 8); ra = 8'(j);
      step();
      chk($sformatf("b%0d rl1 valid", j), 64'(i0.data_valid), 64'(j < 8));
      if (j < 8) chk($sformatf("b%0d rl1 data", j), 64'(i0.data_out), 64'(32'hA0 + 32'(j)));
      chk($sformatf("b%0d rl2 valid", j), 64'(i2.data_valid), 64'(j >= 1 && j <= 8));
      if (j >= 1 && j <= 8) chk($sformatf("b%0d rl2 data", j), 64'(i2.data_out), 64'(32'hA0 + 32'(j - 1)));
    end
    chk("rl2 data hold", 64'(i2.data_out), 64'hA7);
    idle();

    // Counter saturation (4-bit counter already at 3)
    for (int k = 1; k <= 20; k++) begin
      we = 1'b1; wa = 8'h50; din = 32'(k); be = 4'hF; re = 1'b1; ra = 8'h50;
      step();
      chk($sformatf("sat%0d count4", k), 64'(i3.collision_count), 64'((3 + k > 15) ? 15 : 3 + k));
      chk($sformatf("sat%0d coll4", k),  64'(i3.collision), 64'd1);
    end
    idle();
    step();
    chk("sat count16", 64'(i0.collision_count), 64'd23);
    chk("sat idle count4", 64'(i3.collision_count), 64'd15);
    chk("sat idle coll4",  64'(i3.collision), 64'd0);

    // Reset with reads in flight
    re = 1'b1; ra = 8'h10;
    repeat (3) step();
    chk("pre-rst rl2 valid", 64'(i2.data_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid-rst rl1 valid", 64'(i0.data_valid), 64'd0);
    chk("mid-rst rl2 valid", 64'(i2.data_valid), 64'd0);
    chk("mid-rst ready",     64'(i0.ready), 64'd0);
    chk("mid-rst rl1 data",  64'(i0.data_out), 64'd0);
    chk("mid-rst rl2 data",  64'(i2.data_out), 64'd0);
    chk("mid-rst count",     64'(i0.collision_count), 64'd0);
    repeat (2) step();
    chk("in-rst rl2 valid", 64'(i2.data_valid), 64'd0);
    reset = 1'b0;
    wait_ready("refill");

    re = 1'b1; ra = 8'h10;
    step();
    idle();
    chk("refill rl1 valid", 64'(i0.data_valid), 64'd1);
    chk("refill rl1 data",  64'(i0.data_out), 64'd0);
    step();
    chk("refill rl2 valid", 64'(i2.data_valid), 64'd1);
    chk("refill rl2 data",  64'(i2.data_out), 64'd0);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
